sram_port_arbiter: RTL and testbench

//  Shares one single-port SRAM macro (CEB/WEB/A/DI/DO, 1-cycle read latency) between NUM_REQ

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_port_arbiter_rr_pick.sv | 33 +++
 rtl/sram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM port arbiter.
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W = 14;
  localparam int unsigned SRAM_DATA_W = 32;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width that stays legal (>=1 bit) for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping.
module rr_pick
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_cand;

  // Scan ptr+1, ptr+2, ... so the last winner has lowest priority.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between NUM_REQ requesters with
// round-robin arbitration and an optional, time-bounded burst lock.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = SRAM_ADDR_W,
  parameter int unsigned DATA_W   = SRAM_DATA_W,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      CEB,
  output logic                      WEB,
  output logic [ADDR_W-1:0]         A,
  output logic [DATA_W-1:0]         DI,
  input  logic [DATA_W-1:0]         DO
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_lock_cnt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_rsp_valid;

  logic               w_forced;
  logic               w_arb_mode;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt_oh;

  // Lock expiry turns this cycle into an open arbitration round.
  assign w_forced   = (r_state == ARB_LOCKED) && (r_lock_cnt == CNT_W'(MAX_LOCK));
  assign w_arb_mode = (r_state == ARB_IDLE) || w_forced;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_oh),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: enter lock on a locked grant, leave on lock drop or expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_gnt && req_lock[w_gnt_idx]) w_state_nxt = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        if (w_forced) begin
          // Expired owner's lock is ignored; another winner may lock.
          if (w_gnt && (w_gnt_idx != r_owner) && req_lock[w_gnt_idx]) w_state_nxt = ARB_LOCKED;
          else                                                          w_state_nxt = ARB_IDLE;
        end else if (w_gnt && !req_lock[r_owner]) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Grant selection and SRAM pin muxing, combinational in the access cycle.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = r_owner;
    w_gnt_oh  = '0;
    if (!ARESET) begin
      if (w_arb_mode) begin
        w_gnt     = w_pick_any;
        w_gnt_idx = w_pick_idx;
        w_gnt_oh  = w_pick_oh;
      end else if (req_valid[r_owner]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = r_owner;
        w_gnt_oh  = NUM_REQ'(1) << r_owner;
      end
    end
    req_ready = w_gnt_oh;
    CEB       = ~w_gnt;
    WEB       = 1'b1;
    A         = '0;
    DI        = '0;
    if (w_gnt) begin
      WEB = ~req_write[w_gnt_idx];
      A   = req_addr[32'(w_gnt_idx)*ADDR_W +: ADDR_W];
      DI  = req_wdata[32'(w_gnt_idx)*DATA_W +: DATA_W];
    end
  end

  // Owner, lock counter, round-robin pointer and read-response pipeline.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_owner     <= '0;
      r_lock_cnt  <= '0;
      r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
      r_rsp_valid <= '0;
    end else begin
      r_rsp_valid <= w_gnt_oh & ~req_write;
      if (w_gnt) r_rr_ptr <= w_gnt_idx;
      if (w_state_nxt == ARB_LOCKED) begin
        if (w_arb_mode) begin
          r_owner    <= w_gnt_idx;
          r_lock_cnt <= CNT_W'(1);
        end else if (r_lock_cnt != CNT_W'(MAX_LOCK)) begin
          r_lock_cnt <= r_lock_cnt + CNT_W'(1);
        end
      end else begin
        r_lock_cnt <= '0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = DO;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and random stimulus for sram_port_arbiter against a rule-level model.
module tb_sram_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int ML = 8;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [N-1:0]    req_valid, req_write, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            CEB, WEB;
  logic [AW-1:0]   A;
  logic [DW-1:0]   DI;
  logic [DW-1:0]   DO = '0;

  int total = 0;
  int bad   = 0;

  sram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  always #5 ACLK = ~ACLK;

  // SRAM macro behaviour driven from the DUT pins.
  logic [DW-1:0] sram [int];
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] def_val(input int a);
    return 32'hA5A5_0000 ^ DW'(a);
  endfunction

  always @(posedge ACLK) begin
    if (CEB === 1'b0) begin
      if (WEB === 1'b0) sram[int'(A)] = DI;
      else DO <= sram.exists(int'(A)) ? sram[int'(A)] : def_val(int'(A));
    end
  end

  // Reference model state (spec rules, plain integers).
  bit          m_locked;
  int          m_owner, m_held, m_last, m_pend;
  logic [DW-1:0] m_pend_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int after, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(after + k) % N]) return (after + k) % N;
    end
    return -1;
  endfunction

  task automatic preload(input int a, input logic [DW-1:0] d);
    sram[a]    = d;
    ref_mem[a] = d;
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input bit l,
                         input int a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_lock[i]  = l;
    req_addr[i*AW +: AW]  = AW'(a);
    req_wdata[i*DW +: DW] = d;
  endtask

  // One clock: compare combinational and registered outputs, then advance the model.
  task automatic cycle();
    int win;
    bit forced, rst;
    int ea;
    logic [DW-1:0] ed;
    bit ew;
    @(negedge ACLK);
    win = -1;
    rst = ARESET;
    forced = m_locked && (m_held == ML);
    if (!rst) begin
      if (!m_locked || forced)    win = pick(m_last, req_valid);
      else if (req_valid[m_owner]) win = m_owner;
    end
    ea = 0; ed = '0; ew = 1'b0;
    if (win >= 0) begin
      ew = req_write[win];
      ea = int'(req_addr[win*AW +: AW]);
      ed = req_wdata[win*DW +: DW];
    end
    check("ready", 64'(req_ready), (win >= 0) ? 64'(1 << win) : 64'd0);
    check("ceb",   64'(CEB), (win >= 0) ? 64'd0 : 64'd1);
    check("web",   64'(WEB), (win >= 0) ? 64'(!ew) : 64'd1);
    check("addr",  64'(A),   64'(ea));
    check("di",    64'(DI),  64'(ed));
    if (!rst) begin
      check("rsp_valid", 64'(rsp_valid), (m_pend >= 0) ? 64'(1 << m_pend) : 64'd0);
      if (m_pend >= 0) check("rsp_rdata", 64'(rsp_rdata), 64'(m_pend_data));
    end
    @(posedge ACLK);
    if (rst) begin
      m_locked = 0; m_owner = 0; m_held = 0; m_last = N - 1; m_pend = -1;
    end else begin
      m_pend = -1;
      if (win >= 0) begin
        if (ew) ref_mem[ea] = ed;
        else begin
          m_pend = win;
          m_pend_data = ref_mem.exists(ea) ? ref_mem[ea] : def_val(ea);
        end
        m_last = win;
      end
      if (!m_locked) begin
        if (win >= 0 && req_lock[win]) begin m_locked = 1; m_owner = win; m_held = 1; end
      end else if (forced) begin
        if (win >= 0 && win != m_owner && req_lock[win]) begin m_owner = win; m_held = 1; end
        else m_locked = 0;
      end else begin
        m_held++;
        if (win >= 0 && !req_lock[m_owner]) m_locked = 0;
      end
    end
    #1;
  endtask

  initial begin
    int n;
    ARESET = 1'b1;
    req_valid = '0; req_write = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    m_locked = 0; m_owner = 0; m_held = 0; m_last = N - 1; m_pend = -1; m_pend_data = '0;
    preload(16'h0010, 32'hDEAD_BEEF);
    cycle();
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_ceb",   64'(CEB), 64'd1);
    check("rst_web",   64'(WEB), 64'd1);
    cycle();
    ARESET = 1'b0;

    // Single read from requester 0.
    set_req(0, 1, 0, 0, 'h0010, '0);
    #1;
    check("t1_ready", 64'(req_ready), 64'h1);
    check("t1_ceb",   64'(CEB), 64'd0);
    check("t1_web",   64'(WEB), 64'd1);
    check("t1_addr",  64'(A), 64'h0010);
    cycle();
    set_req(0, 0, 0, 0, 0, '0);
    #1;
    check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t1_rdata",     64'(rsp_rdata), 64'hDEAD_BEEF);
    cycle();

    // Single write at the top address.
    set_req(0, 1, 1, 0, 'h3FFF, 32'h1234_5678);
    #1;
    check("t2_ready", 64'(req_ready), 64'h1);
    check("t2_web",   64'(WEB), 64'd0);
    check("t2_di",    64'(DI), 64'h1234_5678);
    cycle();
    set_req(0, 0, 0, 0, 0, '0);
    #1;
    check("t2_no_rsp", 64'(rsp_valid), 64'h0);
    cycle();

    // Both requesters read every cycle, no lock: alternating grants.
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1, 0, 0, i, '0);
      set_req(1, 1, 0, 0, 'h3FFF, '0);
      cycle();
    end

    // Single req0 access so req1 is next in rotation, then a 4-beat locked burst.
    set_req(1, 0, 0, 0, 0, '0);
    cycle();
    for (int b = 0; b < 4; b++) begin
      set_req(0, 1, 0, 0, 'h20, '0);
      set_req(1, 1, 1, (b < 3), 'h30 + b, 32'hB0B0_0000 + 32'(b));
      #1;
      check("t4_burst_owner", 64'(req_ready), 64'h2);
      cycle();
    end
    set_req(1, 0, 0, 0, 0, '0);
    #1;
    check("t4_req0_after", 64'(req_ready), 64'h1);
    cycle();

    // Requester 1 holds the lock forever: req0 must get in on the 8th locked cycle.
    set_req(0, 0, 0, 0, 0, '0);
    set_req(1, 1, 0, 1, 'h40, '0);
    cycle();
    set_req(0, 1, 0, 0, 'h41, '0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      n++;
      if (req_ready[0]) break;
      cycle();
    end
    check("t5_lock_bound", 64'(n), 64'(ML));
    cycle();
    #1;
    check("t5_req1_regains", 64'(req_ready), 64'h2);
    cycle();

    // Reset mid-burst with a read pending.
    set_req(0, 0, 0, 0, 0, '0);
    set_req(1, 1, 0, 1, 'h50, '0);
    cycle();
    ARESET = 1'b1;
    #1;
    check("t6_rst_ready", 64'(req_ready), 64'h0);
    check("t6_rst_ceb",   64'(CEB), 64'd1);
    cycle();
    ARESET = 1'b0;
    set_req(0, 1, 0, 0, 'h60, '0);
    set_req(1, 1, 0, 0, 'h61, '0);
    #1;
    check("t6_rsp_cleared", 64'(rsp_valid), 64'h0);
    check("t6_first_req0",  64'(req_ready), 64'h1);
    cycle();

    // Random traffic with frequent locks and occasional resets.
    for (int c = 0; c < 600; c++) begin
      ARESET = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        set_req(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                ($urandom_range(0, 2) != 0), int'($urandom_range(0, 15)), $urandom);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
